// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the background pixel pipeline.
package ppu_pkg;

  typedef logic [1:0] pixel_t;

  localparam int X_MAX = 160;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    RUN     = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/bg_pixel_shifter.sv
// Parallel-load / serial-shift register for one tile row; slot 0 is the next pixel out.
module bg_pixel_shifter
  import ppu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                i_load,
  input  logic                i_shift,
  input  logic                i_flush,
  input  pixel_t [DEPTH-1:0]  i_pixels,
  output pixel_t              o_head,
  output logic   [CW-1:0]     o_count
);

  pixel_t [DEPTH-1:0] r_slots;
  logic   [CW-1:0]    r_count;

  // NOTE: the slot data needs no reset; r_count alone says which slots are meaningful.
  always_ff @(posedge clk_in) begin
    if (i_load) begin
      r_slots <= i_pixels;
    end else if (i_shift) begin
      r_slots <= {pixel_t'(2'b00), r_slots[DEPTH-1:1]};
    end
  end

  // A load in the same cycle as a flush wins, so a flush-and-reload leaves a full row.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(DEPTH);
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_shift) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_head  = r_slots[0];
  assign o_count = r_count;

endmodule

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: takes 8-pixel rows from the fetcher, applies SCX fine-scroll
// discard and shifts one colour index per T-cycle toward the mixer while tracking X.
module bg_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int X_MAX = ppu_pkg::X_MAX,
  parameter int DEPTH = 8,
  parameter int XW    = $clog2(X_MAX)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               tclk_in,
  input  logic               line_start_in,
  input  logic [2:0]         scx_fine_in,
  input  logic               window_start_in,
  input  logic               stall_in,
  input  logic               push_valid_in,
  input  pixel_t [DEPTH-1:0] push_pixels_in,
  output logic               empty_out,
  output logic               pixel_valid_out,
  output pixel_t             pixel_out,
  output logic [XW-1:0]      X_out,
  output logic               line_done_out,
  output logic               overflow_out
);

  localparam int CW = $clog2(DEPTH + 1);

  fifo_state_t     r_state;
  logic [2:0]      r_discard;
  logic [XW-1:0]   r_x;
  logic            r_line_done;
  logic            r_overflow;
  logic            r_valid;
  pixel_t          r_pixel;
  logic            r_empty;

  pixel_t          w_head;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_next;
  logic            w_flush;
  logic            w_load;
  logic            w_drop;
  logic            w_pop;

  // line_start beats everything; window_start empties the FIFO so a same-cycle push fits.
  assign w_flush = tclk_in && (line_start_in || window_start_in);
  assign w_load  = tclk_in && push_valid_in && !line_start_in &&
                   (window_start_in || (w_count == '0));
  assign w_drop  = tclk_in && push_valid_in && !line_start_in && !window_start_in &&
                   (w_count != '0);
  assign w_pop   = tclk_in && !line_start_in && !window_start_in && !w_load &&
                   (w_count != '0) && !stall_in && !r_line_done;

  // NOTE: every path assigns a value, so this block cannot infer a latch.
  always_comb begin
    w_count_next = w_count;
    if (line_start_in && tclk_in) begin
      w_count_next = '0;
    end else if (w_load) begin
      w_count_next = CW'(DEPTH);
    end else if (w_flush) begin
      w_count_next = '0;
    end else if (w_pop) begin
      w_count_next = w_count - CW'(1);
    end
  end

  bg_pixel_shifter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_shifter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .i_load   (w_load),
    .i_shift  (w_pop),
    .i_flush  (w_flush),
    .i_pixels (push_pixels_in),
    .o_head   (w_head),
    .o_count  (w_count)
  );

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_discard   <= '0;
      r_x         <= '0;
      r_line_done <= 1'b0;
      r_overflow  <= 1'b0;
      r_valid     <= 1'b0;
      r_pixel     <= '0;
      r_empty     <= 1'b1;
    end else if (tclk_in) begin
      r_empty <= (w_count_next == '0);
      if (line_start_in) begin
        r_x         <= '0;
        r_line_done <= 1'b0;
        r_discard   <= scx_fine_in;
        r_valid     <= 1'b0;
        r_state     <= (scx_fine_in != 3'd0) ? DISCARD : RUN;
      end else begin
        r_valid <= 1'b0;
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (window_start_in) begin
          r_discard <= '0;
          if (r_state == DISCARD) begin
            r_state <= RUN;
          end
        end
        if (w_pop) begin
          if (r_state == DISCARD) begin
            r_discard <= r_discard - 3'd1;
            if (r_discard == 3'd1) begin
              r_state <= RUN;
            end
          end else begin
            r_valid <= 1'b1;
            r_pixel <= w_head;
            r_x     <= r_x + XW'(1);
            if (r_x == XW'(X_MAX - 1)) begin
              r_line_done <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
      end
    end
  end

  assign empty_out       = r_empty;
  assign pixel_valid_out = r_valid;
  assign pixel_out       = r_pixel;
  assign X_out           = r_x;
  assign line_done_out   = r_line_done;
  assign overflow_out    = r_overflow;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed bench for bg_pixel_fifo: scroll discard, overflow, stall, window flush,
// async reset and a full 160-pixel line.
module tb_bg_pixel_fifo;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        tclk_in;
  logic        line_start_in;
  logic [2:0]  scx_fine_in;
  logic        window_start_in;
  logic        stall_in;
  logic        push_valid_in;
  logic [15:0] push_pixels_in;
  logic        empty_out;
  logic        pixel_valid_out;
  logic [1:0]  pixel_out;
  logic [7:0]  X_out;
  logic        line_done_out;
  logic        overflow_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  bg_pixel_fifo dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .tclk_in         (tclk_in),
    .line_start_in   (line_start_in),
    .scx_fine_in     (scx_fine_in),
    .window_start_in (window_start_in),
    .stall_in        (stall_in),
    .push_valid_in   (push_valid_in),
    .push_pixels_in  (push_pixels_in),
    .empty_out       (empty_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_out       (pixel_out),
    .X_out           (X_out),
    .line_done_out   (line_done_out),
    .overflow_out    (overflow_out)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] row8(input logic [1:0] p0, input logic [1:0] p1,
                                       input logic [1:0] p2, input logic [1:0] p3,
                                       input logic [1:0] p4, input logic [1:0] p5,
                                       input logic [1:0] p6, input logic [1:0] p7);
    return {p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // One T-cycle; single-cycle request inputs are cleared afterwards.
  task automatic tick();
    tclk_in = 1'b1;
    @(posedge clk_in);
    #1;
    tclk_in         = 1'b0;
    line_start_in   = 1'b0;
    window_start_in = 1'b0;
    push_valid_in   = 1'b0;
  endtask

  task automatic push(input logic [15:0] row);
    push_valid_in  = 1'b1;
    push_pixels_in = row;
    tick();
  endtask

  task automatic line_start(input logic [2:0] scx);
    line_start_in = 1'b1;
    scx_fine_in   = scx;
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic valid, input logic [1:0] pix,
                            input logic [7:0] x);
    tick();
    check({tag, ".valid"}, pixel_valid_out, valid);
    if (valid) check({tag, ".pixel"}, pixel_out, pix);
    check({tag, ".x"}, X_out, x);
  endtask

  initial begin
    logic [15:0] rw;
    logic [1:0]  exp_pix [8];

    rst_in          = 1'b1;
    tclk_in         = 1'b0;
    line_start_in   = 1'b0;
    scx_fine_in     = 3'd0;
    window_start_in = 1'b0;
    stall_in        = 1'b0;
    push_valid_in   = 1'b0;
    push_pixels_in  = '0;
    #12;
    check("rst.empty", empty_out, 1'b1);
    check("rst.valid", pixel_valid_out, 1'b0);
    check("rst.pixel", pixel_out, 2'd0);
    check("rst.x", X_out, 8'd0);
    check("rst.done", line_done_out, 1'b0);
    check("rst.ovf", overflow_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Plain line, no fine scroll.
    line_start(3'd0);
    check("ls0.x", X_out, 8'd0);
    check("ls0.empty", empty_out, 1'b1);
    push(row8(0, 1, 2, 3, 0, 1, 2, 3));
    check("p0.empty", empty_out, 1'b0);
    check("p0.valid", pixel_valid_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pop_expect("row0", 1'b1, 2'(i % 4), 8'(i + 1));
    end
    check("row0.empty", empty_out, 1'b1);

    // Push without a T-cycle enable has no effect.
    push_valid_in  = 1'b1;
    push_pixels_in = row8(1, 1, 1, 1, 1, 1, 1, 1);
    @(posedge clk_in);
    #1;
    push_valid_in = 1'b0;
    check("notclk.empty", empty_out, 1'b1);
    check("notclk.x", X_out, 8'd8);

    // Fine scroll of 3 discards the first three pixels of row A.
    line_start(3'd3);
    check("ls3.x", X_out, 8'd0);
    check("ls3.valid", pixel_valid_out, 1'b0);
    push(row8(3, 3, 3, 1, 2, 0, 1, 2));
    for (int i = 0; i < 3; i++) begin
      pop_expect("discard", 1'b0, 2'd0, 8'd0);
    end
    exp_pix = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      pop_expect("rowA", 1'b1, exp_pix[i], 8'(i + 1));
    end
    check("rowA.empty", empty_out, 1'b1);

    // Push while 4 pixels remain is dropped and flags overflow.
    push(row8(1, 2, 3, 0, 1, 2, 3, 0));
    exp_pix = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      pop_expect("rowB", 1'b1, exp_pix[i], 8'(6 + i));
    end
    check("pre_ovf.ovf", overflow_out, 1'b0);
    push(row8(3, 3, 3, 3, 3, 3, 3, 3));
    check("ovf.ovf", overflow_out, 1'b1);
    check("ovf.valid", pixel_valid_out, 1'b1);
    check("ovf.pixel", pixel_out, 2'd1);
    check("ovf.x", X_out, 8'd10);
    for (int i = 5; i < 8; i++) begin
      pop_expect("rowB_tail", 1'b1, exp_pix[i], 8'(6 + i));
    end
    check("rowB.empty", empty_out, 1'b1);

    // Stall with 3 pixels left freezes output and X.
    push(row8(1, 1, 1, 1, 1, 2, 3, 1));
    for (int i = 0; i < 5; i++) begin
      pop_expect("rowD", 1'b1, 2'd1, 8'(14 + i));
    end
    stall_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pop_expect("stall", 1'b0, 2'd0, 8'd18);
    end
    check("stall.empty", empty_out, 1'b0);
    stall_in = 1'b0;
    pop_expect("resume0", 1'b1, 2'd2, 8'd19);
    pop_expect("resume1", 1'b1, 2'd3, 8'd20);
    pop_expect("resume2", 1'b1, 2'd1, 8'd21);
    check("rowD.empty", empty_out, 1'b1);

    // Window start flushes the rest of row E; a same-cycle push of row F is kept.
    push(row8(2, 2, 2, 2, 2, 2, 2, 2));
    for (int i = 0; i < 5; i++) begin
      pop_expect("rowE", 1'b1, 2'd2, 8'(22 + i));
    end
    window_start_in = 1'b1;
    push(row8(3, 0, 3, 0, 3, 0, 3, 0));
    check("win.valid", pixel_valid_out, 1'b0);
    check("win.x", X_out, 8'd26);
    check("win.empty", empty_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pop_expect("rowF", 1'b1, (i % 2 == 0) ? 2'd3 : 2'd0, 8'(27 + i));
    end
    check("rowF.empty", empty_out, 1'b1);

    // Asynchronous reset mid-row: count 5, X 37.
    push(row8(1, 2, 3, 1, 1, 1, 1, 1));
    pop_expect("rowG0", 1'b1, 2'd1, 8'd35);
    pop_expect("rowG1", 1'b1, 2'd2, 8'd36);
    pop_expect("rowG2", 1'b1, 2'd3, 8'd37);
    rst_in = 1'b1;
    #1;
    check("arst.empty", empty_out, 1'b1);
    check("arst.valid", pixel_valid_out, 1'b0);
    check("arst.pixel", pixel_out, 2'd0);
    check("arst.x", X_out, 8'd0);
    check("arst.ovf", overflow_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Twenty back-to-back rows fill the 160-pixel line.
    line_start(3'd0);
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) rw[2*i +: 2] = 2'((r + i) % 4);
      push(rw);
      check("full.gap_valid", pixel_valid_out, 1'b0);
      for (int i = 0; i < 8; i++) begin
        pop_expect("full", 1'b1, 2'((r + i) % 4), 8'(8 * r + i + 1));
      end
    end
    check("full.x", X_out, 8'd160);
    check("full.done", line_done_out, 1'b1);
    check("full.empty", empty_out, 1'b1);

    // Row 21 is accepted but held until the next line starts.
    push(row8(1, 2, 3, 1, 2, 3, 1, 2));
    check("r21.empty", empty_out, 1'b0);
    check("r21.ovf", overflow_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pop_expect("r21.hold", 1'b0, 2'd0, 8'd160);
    end
    check("r21.hold_empty", empty_out, 1'b0);
    line_start(3'd0);
    check("next.empty", empty_out, 1'b1);
    check("next.x", X_out, 8'd0);
    check("next.done", line_done_out, 1'b0);
    check("next.valid", pixel_valid_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
